// File: rtl/fir_pe_if.sv
// Bus bundle for one fir_pe: broadcast sample/tap/control in,
// partial sum in from the previous PE, registered partial sum out.
interface fir_pe_if #(
    parameter int DW = 16,
    parameter int SW = 4
);
    logic              in_valid;
    logic [2*DW-1:0]   in_sample;
    logic [2*DW-1:0]   tap;
    logic              flush;
    logic              enable;
    logic              is_auto;
    logic [SW-1:0]     shift;
    logic [2*DW-1:0]   psum_in;
    logic [2*DW-1:0]   psum_out;

    modport master (
        output in_valid, in_sample, tap, flush,
        output enable, is_auto, shift, psum_in,
        input  psum_out
    );

    modport slave (
        input  in_valid, in_sample, tap, flush,
        input  enable, is_auto, shift, psum_in,
        output psum_out
    );
endinterface

// File: rtl/fir_pe.sv
// Complex MAC processing element of a transposed systolic FIR tile:
// psum_out <= sat(psum_in + sat((x * tap[conj]) >>> shift)).
module fir_pe #(
    parameter int DW = 16,
    parameter int SW = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    fir_pe_if.slave  bus
);
    localparam int PW = 2 * DW;

    logic signed [DW-1:0] w_a, w_b, w_c, w_d;
    logic signed [PW-1:0] w_ac, w_bd, w_ad, w_bc;
    logic signed [PW:0]   w_pre, w_pim;
    logic signed [PW:0]   w_pre_sh, w_pim_sh;
    logic [DW-1:0]        w_pre_sat, w_pim_sat;
    logic [DW:0]          w_sre, w_sim;
    logic [DW-1:0]        w_sre_sat, w_sim_sat;
    logic [PW-1:0]        r_psum;

    function automatic logic [DW-1:0] sat_prod(
        input logic signed [PW:0] v
    );
        if ((&v[PW:DW-1]) || ~(|v[PW:DW-1]))
            return v[DW-1:0];
        return v[PW] ? {1'b1, {(DW-1){1'b0}}}
                     : {1'b0, {(DW-1){1'b1}}};
    endfunction

    // Sum is one bit wider than its operands: overflow iff top two bits differ
    function automatic logic [DW-1:0] sat_sum(
        input logic [DW:0] v
    );
        if (v[DW] == v[DW-1])
            return v[DW-1:0];
        return v[DW] ? {1'b1, {(DW-1){1'b0}}}
                     : {1'b0, {(DW-1){1'b1}}};
    endfunction

    assign w_a = bus.in_sample[PW-1:DW];
    assign w_b = bus.in_sample[DW-1:0];
    assign w_c = bus.tap[PW-1:DW];
    assign w_d = bus.tap[DW-1:0];

    assign w_ac = {{DW{w_a[DW-1]}}, w_a} * {{DW{w_c[DW-1]}}, w_c};
    assign w_bd = {{DW{w_b[DW-1]}}, w_b} * {{DW{w_d[DW-1]}}, w_d};
    assign w_ad = {{DW{w_a[DW-1]}}, w_a} * {{DW{w_d[DW-1]}}, w_d};
    assign w_bc = {{DW{w_b[DW-1]}}, w_b} * {{DW{w_c[DW-1]}}, w_c};

    always_comb begin
        w_pre = '0;
        w_pim = '0;
        if (bus.is_auto) begin
            w_pre = {w_ac[PW-1], w_ac} + {w_bd[PW-1], w_bd};
            w_pim = {w_bc[PW-1], w_bc} - {w_ad[PW-1], w_ad};
        end else begin
            w_pre = {w_ac[PW-1], w_ac} - {w_bd[PW-1], w_bd};
            w_pim = {w_ad[PW-1], w_ad} + {w_bc[PW-1], w_bc};
        end
    end

    assign w_pre_sh  = w_pre >>> bus.shift;
    assign w_pim_sh  = w_pim >>> bus.shift;
    assign w_pre_sat = sat_prod(w_pre_sh);
    assign w_pim_sat = sat_prod(w_pim_sh);

    assign w_sre = {bus.psum_in[PW-1], bus.psum_in[PW-1:DW]}
                 + {w_pre_sat[DW-1], w_pre_sat};
    assign w_sim = {bus.psum_in[DW-1], bus.psum_in[DW-1:0]}
                 + {w_pim_sat[DW-1], w_pim_sat};
    assign w_sre_sat = sat_sum(w_sre);
    assign w_sim_sat = sat_sum(w_sim);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_psum <= '0;
        else if (bus.flush)
            r_psum <= '0;
        else if (bus.enable && bus.in_valid)
            r_psum <= {w_sre_sat, w_sim_sat};
    end

    assign bus.psum_out = r_psum;
endmodule

// File: tb/tb_fir_pe.sv
// Scoreboard bench for fir_pe: a longint reference model pushes the
// expected psum per cycle, popped and compared after each edge.
module tb_fir_pe;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    logic [31:0] sb_q[$];
    logic [31:0] mdl_psum;

    fir_pe_if #(.DW(16), .SW(4)) bus ();

    fir_pe #(.DW(16), .SW(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767)
            return 32767;
        if (v < -32768)
            return -32768;
        return v;
    endfunction

    function automatic logic [31:0] mac(
        input logic [31:0] x,
        input logic [31:0] t,
        input logic [31:0] p,
        input bit          auto,
        input int          sh
    );
        logic signed [15:0] xa, xb, tc, td, pr16, pi16;
        longint a, b, c, d, pr, pi, sr, si;
        xa = x[31:16]; xb = x[15:0];
        tc = t[31:16]; td = t[15:0];
        pr16 = p[31:16]; pi16 = p[15:0];
        a = xa; b = xb; c = tc; d = td;
        if (auto) begin
            pr = a * c + b * d;
            pi = b * c - a * d;
        end else begin
            pr = a * c - b * d;
            pi = a * d + b * c;
        end
        pr = pr >>> sh;
        pi = pi >>> sh;
        sr = sat16(longint'(pr16) + sat16(pr));
        si = sat16(longint'(pi16) + sat16(pi));
        return {sr[15:0], si[15:0]};
    endfunction

    function automatic logic [31:0] cx(input int re, input int im);
        logic [15:0] r, i;
        r = re[15:0];
        i = im[15:0];
        return {r, i};
    endfunction

    task automatic step(
        input string       tag,
        input bit          rst,
        input bit          fl,
        input bit          en,
        input bit          vld,
        input bit          auto,
        input int          sh,
        input logic [31:0] x,
        input logic [31:0] t,
        input logic [31:0] p
    );
        logic [31:0] exp;
        rst_n         = ~rst;
        bus.flush     = fl;
        bus.enable    = en;
        bus.in_valid  = vld;
        bus.is_auto   = auto;
        bus.shift     = sh[3:0];
        bus.in_sample = x;
        bus.tap       = t;
        bus.psum_in   = p;
        if (rst || fl)
            mdl_psum = '0;
        else if (en && vld)
            mdl_psum = mac(x, t, p, auto, sh);
        sb_q.push_back(mdl_psum);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            exp = sb_q.pop_front();
            check(tag, bus.psum_out, exp);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        mdl_psum = '0;

        step("rst0", 1, 0, 0, 0, 0, 0, '0, '0, '0);
        step("rst1", 1, 0, 1, 1, 0, 0, cx(7, 7), cx(7, 7), cx(1, 1));
        check("rst_state", bus.psum_out, '0);

        step("basic", 0, 0, 1, 1, 0, 0, cx(3, 4), cx(2, 1), cx(100, -50));
        check("basic_k", bus.psum_out, cx(102, -39));

        for (int i = 0; i < 3; i++)
            step("hold_v", 0, 0, 1, 0, i[0], i, cx(i + 9, -5),
                 cx(-3, i), cx(55, 66));
        check("hold_k", bus.psum_out, cx(102, -39));
        for (int i = 0; i < 3; i++)
            step("hold_e", 0, 0, 0, 1, 1, 2, cx(1000, i),
                 cx(-999, 4), cx(-7, 8));
        check("hold_e_k", bus.psum_out, cx(102, -39));

        step("corr", 0, 0, 1, 1, 1, 0, cx(3, 4), cx(2, 1), cx(100, -50));
        check("corr_k", bus.psum_out, cx(110, -45));

        step("satp", 0, 0, 1, 1, 0, 0, cx(32767, 0), cx(32767, 0), '0);
        check("satp_k", {16'h0, bus.psum_out[31:16]}, 32'd32767);
        step("shf15", 0, 0, 1, 1, 0, 15, cx(32767, 0), cx(32767, 0), '0);
        check("shf15_k", {16'h0, bus.psum_out[31:16]}, 32'd32766);
        step("satn", 0, 0, 1, 1, 0, 0, cx(-32768, 0), cx(32767, 0),
             cx(-100, 0));
        check("satn_k", {16'h0, bus.psum_out[31:16]}, 32'h8000);

        step("neg1", 0, 0, 1, 1, 0, 15, cx(-1, 0), cx(1, 0), cx(0, 0));
        check("neg1_k", bus.psum_out, cx(-1, 0));

        step("pre_fl", 0, 0, 1, 1, 0, 0, cx(3, 4), cx(2, 1), cx(100, -50));
        step("flush", 0, 1, 1, 1, 0, 0, cx(3, 4), cx(2, 1), cx(100, -50));
        check("flush_k", bus.psum_out, '0);

        step("pre_rst", 0, 0, 1, 1, 1, 0, cx(3, 4), cx(2, 1), cx(100, -50));
        step("mid_rst", 1, 0, 1, 1, 1, 0, cx(3, 4), cx(2, 1), cx(100, -50));
        check("mid_rst_k", bus.psum_out, '0);
        step("resume", 0, 0, 1, 1, 0, 0, cx(3, 4), cx(2, 1), cx(100, -50));
        check("resume_k", bus.psum_out, cx(102, -39));

        for (int i = 0; i < 200; i++) begin
            int sel;
            logic [31:0] x, t, p;
            sel = int'($urandom_range(0, 3));
            x = $urandom();
            t = $urandom();
            p = $urandom();
            if (sel == 0) begin
                x = (i % 2 == 0) ? 32'h7fff_8000 : 32'h8000_8000;
                t = 32'h8000_7fff;
            end
            step("rand", $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 4) != 0,
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)), x, t, p);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fir_pe.md
Name: fir_pe

Overview:
- Single processing element of a transposed-form systolic FIR / correlator tile.
- Each cycle it multiplies the broadcast input sample by its locally held complex tap, then scales, saturates and adds the product to the partial sum from the previous PE.
- The result is registered toward the next PE. Eight instances are chained per tile.

Parameters:
- DW, 16, width of each signed complex component (sample word = 2*DW bits, {re, im}).
- SW, 4, width of the product right-shift amount.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  broadcast input sample is valid this cycle
- in_sample  in  2*DW  complex input sample, re = [2DW-1:DW], im = [DW-1:0], two's complement
- tap  in  2*DW  complex coefficient, same format, stable from tile tap buffer
- flush  in  1  clear accumulated partial-sum register
- enable  in  1  PE compute enable
- is_auto  in  1  1 = correlation mode (conjugate tap), 0 = convolution mode
- shift  in  SW  arithmetic right-shift applied to each product component
- psum_in  in  2*DW  partial sum from previous PE (first PE: tile input psum)
- psum_out  out  2*DW  registered partial sum to next PE

Behaviour:
- Reset: on a clk edge with rst_n=0, psum_out <= 0. This has priority over all other inputs.
- Notation: x=(a,b)=in_sample, t=(c,d)=tap, all signed DW bits.
- Full-precision products are 2*DW+1 bits signed, with no intermediate overflow.
- is_auto=0: P_re = a*c - b*d, P_im = a*d + b*c.
- is_auto=1 (conjugate tap): P_re = a*c + b*d, P_im = b*c - a*d.
- Scaling: each component is arithmetically right-shifted by shift (floor, no rounding).
- The shifted value is saturated to signed DW bits: [-2^(DW-1), 2^(DW-1)-1].
- Accumulate: S_re = sat_DW(psum_in.re + P_re'), S_im = sat_DW(psum_in.im + P_im'). Each sum is computed at DW+1 bits, then saturated.
- Register update priority at each clk edge (rst_n=1):
  1. flush=1 -> psum_out <= 0, regardless of enable/valid.
  2. enable=1 and in_valid=1 -> psum_out <= {S_re, S_im}.
  3. Otherwise -> psum_out holds its value. The partial-sum chain stalls on bubbles.
- Latency: exactly 1 clk from inputs to psum_out. No combinational path from any input to psum_out.
- tap, shift and is_auto are sampled in the same cycle as in_sample, with no internal holding.
- A shift value ≥ 2*DW+1 yields 0 for non-negative products and -1 for negative products before saturation.
- Simultaneous flush and valid: flush wins; the sample is discarded.
- Reset mid-stream: register cleared; operation resumes on the first cycle with rst_n=1.
- Purely datapath: no FSM, no handshake back-pressure.

Test Plan:
- Basic multiply-accumulate:
  - stimulus: rst_n=0 for 2 cycles, then enable=1, in_valid=1, is_auto=0, shift=0, x=(3,4), t=(2,1), psum_in=(100,-50)
  - required: next cycle psum_out=(102,-39)
- Correlation mode:
  - stimulus: same as above but is_auto=1
  - required: psum_out=(110,-45), from P=(10,5)
- Saturation and shift:
  - stimulus: x=(32767,0), t=(32767,0), psum_in=0, shift=0
  - required: psum_out.re=32767
  - stimulus: repeat with shift=15
  - required: psum_out.re=32766
- Negative saturation:
  - stimulus: x=(-32768,0), t=(32767,0), psum_in.re=-100, shift=0
  - required: psum_out.re=-32768
- Stall/hold:
  - stimulus: load psum_out=(102,-39), then hold in_valid=0 (or enable=0) for 3 cycles with arbitrary inputs
  - required: psum_out stays (102,-39)
- Flush priority:
  - stimulus: flush=1 together with in_valid=1, enable=1
  - required: psum_out=0 next cycle
  - stimulus: assert rst_n=0 mid-stream
  - required: psum_out=0 on the following edge
